move_score_selector: RTL and testbench
======================================

Name: move_score_selector

Overview:
- Downstream consumer of the board evaluator's material score.
- Receives a stream of candidate moves, each with its evaluated score and checkmate/stalemate flags, over a valid/ready handshake.
- Tracks the best candidate for the side to move and reports the selected move, its score and the candidate count when the list ends.
- Sits between the move-generation/evaluation pipeline and the move-commit logic.

Parameters:
- SCORE_W, 16, width of signed two's-complement score.
- MOVE_W, 12, move encoding width, {from[5:0], to[5:0]}.
- MATE_SCORE, 16'sh7FFF, magnitude substituted for a checkmate result.
- CNT_W, 8, candidate counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a new selection.
- start_empty  in  1  qualifies start: the list has zero candidates.
- white_to_move  in  1  side to move; sampled on accepted start.
- cand_valid  in  1  candidate beat valid.
- cand_ready  out  1  selector accepts a beat.
- cand_move  in  MOVE_W  candidate move.
- cand_score  in  SCORE_W  signed evaluator score; positive favours white.
- cand_mate  in  2  2'b10 = white mated, 2'b01 = black mated, other = none.
- cand_stalemate  in  1  position after the move is stalemate.
- cand_last  in  1  final candidate of the list.
- busy  out  1  high in COLLECT and DONE.
- best_valid  out  1  one-cycle result pulse.
- best_move  out  MOVE_W  selected move.
- best_score  out  SCORE_W  effective score of the selected move.
- cand_count  out  CNT_W  candidates accepted in the current or last list.
- no_moves  out  1  last list was empty.

Behaviour:
- Reset: state IDLE. cand_ready, busy, best_valid, no_moves = 0. best_move = 0, best_score = 0, cand_count = 0.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - cand_ready = 0.
  - start with start_empty = 0 -> COLLECT. Latch white_to_move, clear has_best, clear cand_count.
  - start with start_empty = 1 -> DONE. Set best_move = 0, best_score = 0, cand_count = 0, no_moves = 1.
  - Any start clears no_moves before it is re-evaluated.
- COLLECT:
  - cand_ready = 1 combinationally.
  - A beat is accepted when cand_valid && cand_ready.
  - start is ignored.
  - Accepted beat with cand_last = 1 -> DONE.
- DONE:
  - best_valid = 1 for exactly one cycle, then -> IDLE.
  - cand_ready = 0.
  - start is ignored.
- Latency: best_valid asserts in the cycle after the last beat is accepted, or after an empty start.
- Effective score per beat, in priority order:
  - cand_mate = 2'b01 -> +MATE_SCORE.
  - cand_mate = 2'b10 -> -MATE_SCORE (16'sh8001).
  - Otherwise, cand_stalemate = 1 -> 0.
  - Otherwise -> cand_score unchanged.
  - cand_mate = 2'b11 is treated as no mate.
- Selection:
  - The first accepted beat is always taken.
  - Afterwards, replace the held best only on strict improvement: greater score if white to move, less if black. Ties keep the earlier candidate.
  - Comparison is signed, at full SCORE_W; no arithmetic on scores, so no overflow is possible.
- Outputs:
  - best_move and best_score update on each replacement.
  - Both hold their value from DONE until the next accepted start.
- cand_count:
  - Increments per accepted beat.
  - Saturates at 2^CNT_W-1.
- Stability: changing white_to_move mid-list has no effect; only the value latched at start is used.
- Reset mid-COLLECT: synchronous return to reset values. The partial list is discarded and no best_valid is generated.
- Simultaneous rst and start: rst wins.
- cand_valid in IDLE or DONE: not accepted, no effect.

Test Plan:
- White to move; scores +5, -3, +12 (last) -> best_valid one cycle after third beat; best_move = third move; best_score = 12; cand_count = 3.
- Same stream, black to move -> best_move = second move; best_score = -3 (16'hFFFD).
- White to move; scores 7, 7, 2 (last) -> first move kept on tie; best_score = 7.
- Black to move; beat A score -20 with stalemate = 1, beat B score -4 with mate = 2'b10 (last) -> best_move = B; best_score = 16'sh8001.
- start with start_empty = 1 -> best_valid next cycle; no_moves = 1; cand_count = 0; best_score = 0. A following start with a non-empty list clears no_moves.
- rst pulsed after 2 beats of a 4-beat list -> no best_valid; all outputs at reset values. A new start then runs a clean selection. Also check cand_valid held low for several cycles mid-list stalls with no state change.

Source files
------------

// File: rtl/move_score_selector.sv
// Picks the best candidate move from an evaluated move list for the side to move,
// and reports the chosen move, its effective score and the candidate count when the list ends.
module move_score_selector #(
  parameter int                         SCORE_W    = 16,
  parameter int                         MOVE_W     = 12,
  parameter logic signed [SCORE_W-1:0]  MATE_SCORE = 16'sh7FFF,
  parameter int                         CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      start_empty,
  input  logic                      white_to_move,
  input  logic                      cand_valid,
  output logic                      cand_ready,
  input  logic [MOVE_W-1:0]         cand_move,
  input  logic signed [SCORE_W-1:0] cand_score,
  input  logic [1:0]                cand_mate,
  input  logic                      cand_stalemate,
  input  logic                      cand_last,
  output logic                      busy,
  output logic                      best_valid,
  output logic [MOVE_W-1:0]         best_move,
  output logic signed [SCORE_W-1:0] best_score,
  output logic [CNT_W-1:0]          cand_count,
  output logic                      no_moves
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        wtm_q, wtm_d;
  logic                        has_best_q, has_best_d;
  logic [MOVE_W-1:0]           best_move_q, best_move_d;
  logic signed [SCORE_W-1:0]   best_score_q, best_score_d;
  logic [CNT_W-1:0]            cand_count_q, cand_count_d;
  logic                        no_moves_q, no_moves_d;
  logic signed [SCORE_W-1:0]   eff_score;
  logic                        accept;

  // Mate outranks stalemate, which outranks the raw material score; 2'b11 counts as no mate.
  function automatic logic signed [SCORE_W-1:0] effective_score(
    input logic signed [SCORE_W-1:0] score,
    input logic [1:0]                mate,
    input logic                      stalemate
  );
    logic signed [SCORE_W-1:0] r;
    case (mate)
      2'b01:   r = MATE_SCORE;
      2'b10:   r = -MATE_SCORE;
      default: r = stalemate ? '0 : score;
    endcase
    return r;
  endfunction

  // Strict improvement only, so ties keep the earlier candidate.
  function automatic logic is_better(
    input logic signed [SCORE_W-1:0] cand,
    input logic signed [SCORE_W-1:0] held,
    input logic                      for_white
  );
    return for_white ? (cand > held) : (cand < held);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign accept    = (state_q == S_COLLECT) && cand_valid;
  assign eff_score = effective_score(cand_score, cand_mate, cand_stalemate);

  always_comb begin
    state_d      = state_q;
    wtm_d        = wtm_q;
    has_best_d   = has_best_q;
    best_move_d  = best_move_q;
    best_score_d = best_score_q;
    cand_count_d = cand_count_q;
    no_moves_d   = no_moves_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          no_moves_d = 1'b0;
          wtm_d      = white_to_move;
          if (start_empty) begin
            state_d      = S_DONE;
            best_move_d  = '0;
            best_score_d = '0;
            cand_count_d = '0;
            no_moves_d   = 1'b1;
          end else begin
            state_d      = S_COLLECT;
            has_best_d   = 1'b0;
            cand_count_d = '0;
          end
        end
      end
      S_COLLECT: begin
        if (accept) begin
          if (!has_best_q || is_better(eff_score, best_score_q, wtm_q)) begin
            best_move_d  = cand_move;
            best_score_d = eff_score;
          end
          has_best_d   = 1'b1;
          cand_count_d = sat_inc(cand_count_q);
          if (cand_last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wtm_q        <= 1'b0;
      has_best_q   <= 1'b0;
      best_move_q  <= '0;
      best_score_q <= '0;
      cand_count_q <= '0;
      no_moves_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wtm_q        <= wtm_d;
      has_best_q   <= has_best_d;
      best_move_q  <= best_move_d;
      best_score_q <= best_score_d;
      cand_count_q <= cand_count_d;
      no_moves_q   <= no_moves_d;
    end
  end

  assign cand_ready = (state_q == S_COLLECT);
  assign busy       = (state_q != S_IDLE);
  assign best_valid = (state_q == S_DONE);
  assign best_move  = best_move_q;
  assign best_score = best_score_q;
  assign cand_count = cand_count_q;
  assign no_moves   = no_moves_q;

endmodule

// File: tb/tb_move_score_selector.sv
// Randomized and directed bench for move_score_selector against a list-level reference model.
module tb_move_score_selector;

  logic               clk = 1'b0;
  logic               rst, start, start_empty, white_to_move;
  logic               cand_valid, cand_ready;
  logic [11:0]        cand_move;
  logic signed [15:0] cand_score;
  logic [1:0]         cand_mate;
  logic               cand_stalemate, cand_last;
  logic               busy, best_valid, no_moves;
  logic [11:0]        best_move;
  logic signed [15:0] best_score;
  logic [7:0]         cand_count;

  int checks = 0;
  int errors = 0;

  int m_move  [300];
  int m_score [300];
  int m_mate  [300];
  int m_stale [300];

  always #5 clk = ~clk;

  move_score_selector dut (
    .clk(clk), .rst(rst), .start(start), .start_empty(start_empty),
    .white_to_move(white_to_move), .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_move(cand_move), .cand_score(cand_score), .cand_mate(cand_mate),
    .cand_stalemate(cand_stalemate), .cand_last(cand_last), .busy(busy),
    .best_valid(best_valid), .best_move(best_move), .best_score(best_score),
    .cand_count(cand_count), .no_moves(no_moves)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int i);
    if (m_mate[i] == 1) return 32767;
    if (m_mate[i] == 2) return -32767;
    if (m_stale[i] != 0) return 0;
    return m_score[i];
  endfunction

  function automatic int model_best(input bit wtm, input int n);
    int b = 0;
    for (int i = 1; i < n; i++)
      if (wtm ? (eff(i) > eff(b)) : (eff(i) < eff(b))) b = i;
    return b;
  endfunction

  task automatic set_beat(input int i, input int mv, input int sc, input int mt, input int st);
    m_move[i] = mv; m_score[i] = sc; m_mate[i] = mt; m_stale[i] = st;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic run_list(input bit wtm, input int n, input bit gaps);
    int b, exp_cnt;
    logic [15:0] exp_sc;
    start = 1; start_empty = 0; white_to_move = wtm;
    cycle();
    start = 0;
    chk("busy_after_start", {31'b0, busy}, 1);
    chk("ready_in_collect", {31'b0, cand_ready}, 1);
    chk("count_cleared", {24'b0, cand_count}, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          cand_valid = 0; white_to_move = 1'($urandom);
          start = ($urandom_range(0, 3) == 0); start_empty = 1'($urandom);
          cycle();
          start = 0;
          chk("stall_count", {24'b0, cand_count}, (i > 255) ? 255 : i);
          chk("stall_no_result", {31'b0, best_valid}, 0);
        end
      end
      cand_valid = 1; cand_move = 12'(m_move[i]); cand_score = 16'(m_score[i]);
      cand_mate = 2'(m_mate[i]); cand_stalemate = (m_stale[i] != 0); cand_last = (i == n - 1);
      cycle();
      cand_valid = 0; cand_last = 0;
    end
    b = model_best(wtm, n);
    exp_sc = 16'(eff(b));
    exp_cnt = (n > 255) ? 255 : n;
    chk("best_valid", {31'b0, best_valid}, 1);
    chk("best_move", {20'b0, best_move}, 32'(m_move[b]));
    chk("best_score", {16'b0, best_score}, {16'b0, exp_sc});
    chk("cand_count", {24'b0, cand_count}, 32'(exp_cnt));
    chk("no_moves_clear", {31'b0, no_moves}, 0);
    chk("ready_in_done", {31'b0, cand_ready}, 0);
    cand_valid = 1;
    cycle();
    cand_valid = 0;
    chk("best_valid_one_cycle", {31'b0, best_valid}, 0);
    chk("idle_not_busy", {31'b0, busy}, 0);
    chk("hold_move", {20'b0, best_move}, 32'(m_move[b]));
    chk("hold_count", {24'b0, cand_count}, 32'(exp_cnt));
  endtask

  initial begin
    rst = 1; start = 0; start_empty = 0; white_to_move = 0; cand_valid = 0;
    cand_move = 0; cand_score = 0; cand_mate = 0; cand_stalemate = 0; cand_last = 0;
    cycle(); cycle();
    rst = 0;
    chk("rst_ready", {31'b0, cand_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_best_valid", {31'b0, best_valid}, 0);
    chk("rst_no_moves", {31'b0, no_moves}, 0);
    chk("rst_move", {20'b0, best_move}, 0);
    chk("rst_score", {16'b0, best_score}, 0);
    chk("rst_count", {24'b0, cand_count}, 0);

    // White: +5, -3, +12 -> third move, 12
    set_beat(0, 12'h0A1, 5, 0, 0); set_beat(1, 12'h0B2, -3, 0, 0); set_beat(2, 12'h0C3, 12, 0, 0);
    run_list(1, 3, 0);
    chk("t1_move", {20'b0, best_move}, 32'h0C3);
    chk("t1_score", {16'b0, best_score}, 32'h000C);
    // Same stream for black -> second move, -3
    run_list(0, 3, 0);
    chk("t2_score", {16'b0, best_score}, 32'hFFFD);
    // Tie keeps first
    set_beat(0, 12'h111, 7, 0, 0); set_beat(1, 12'h222, 7, 0, 0); set_beat(2, 12'h333, 2, 0, 0);
    run_list(1, 3, 0);
    chk("t3_move", {20'b0, best_move}, 32'h111);
    // Black: stalemate beat vs white-mated beat
    set_beat(0, 12'h444, -20, 0, 1); set_beat(1, 12'h555, -4, 2, 0);
    run_list(0, 2, 0);
    chk("t4_score", {16'b0, best_score}, 32'h8001);
    // mate 2'b11 behaves as no mate
    set_beat(0, 12'h666, 3, 3, 0); set_beat(1, 12'h777, 9, 3, 1);
    run_list(1, 2, 1);

    // Empty list
    start = 1; start_empty = 1; white_to_move = 1;
    cycle();
    start = 0;
    chk("empty_best_valid", {31'b0, best_valid}, 1);
    chk("empty_no_moves", {31'b0, no_moves}, 1);
    chk("empty_count", {24'b0, cand_count}, 0);
    chk("empty_score", {16'b0, best_score}, 0);
    chk("empty_move", {20'b0, best_move}, 0);
    cycle();
    chk("empty_pulse_end", {31'b0, best_valid}, 0);
    chk("empty_no_moves_hold", {31'b0, no_moves}, 1);
    set_beat(0, 12'h9AB, -100, 0, 0);
    run_list(0, 1, 0);

    // Reset in the middle of a 4-beat list
    start = 1; start_empty = 0; white_to_move = 1;
    cycle();
    start = 0;
    for (int i = 0; i < 2; i++) begin
      cand_valid = 1; cand_move = 12'(i + 1); cand_score = 16'(i * 10); cand_mate = 0;
      cand_stalemate = 0; cand_last = 0;
      cycle();
    end
    cand_valid = 0;
    cycle(); cycle();
    chk("stall_no_change", {24'b0, cand_count}, 2);
    rst = 1;
    cycle();
    rst = 0;
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_ready", {31'b0, cand_ready}, 0);
    chk("mid_rst_move", {20'b0, best_move}, 0);
    chk("mid_rst_score", {16'b0, best_score}, 0);
    chk("mid_rst_count", {24'b0, cand_count}, 0);
    cand_valid = 1; cand_last = 1;
    repeat (3) begin
      cycle();
      chk("idle_valid_ignored", {24'b0, cand_count}, 0);
      chk("mid_rst_no_result", {31'b0, best_valid}, 0);
    end
    cand_valid = 0; cand_last = 0;
    // rst and start together: rst wins
    rst = 1; start = 1;
    cycle();
    rst = 0; start = 0;
    chk("rst_beats_start", {31'b0, busy}, 0);
    set_beat(0, 12'h321, 4, 0, 0); set_beat(1, 12'h654, -8, 0, 0); set_beat(2, 12'h987, 1, 1, 0);
    run_list(1, 3, 1);

    // Random lists
    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++)
        set_beat(i, $urandom_range(0, 4095),
                 ($urandom_range(0, 1) != 0) ? ($urandom_range(0, 10) - 5) : int'($signed(16'($urandom))),
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : 0,
                 ($urandom_range(0, 5) == 0) ? 1 : 0);
      run_list(1'($urandom), n, 1);
    end

    // Counter saturation
    for (int i = 0; i < 260; i++) set_beat(i, i, $urandom_range(0, 2000) - 1000, 0, 0);
    run_list(1'($urandom), 260, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
